// File: rtl/corr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : corr_scheduler
//  Description : Two-requester front end for a shared correlator. Grants one
//                requester, latches its sample window and the shared template
//                as correlator operands, sequences CLEAR -> RUN -> CAPTURE and
//                reports the captured peak (or a timeout abort).
//                Optional macro CORR_SCHED_FIXED_PRIO_EN: requester 0 always
//                wins simultaneous requests (no round-robin pointer).
//  Revision    : 1.0 - initial release
// ============================================================================
module corr_scheduler #(
    parameter logic [9:0]  THRESH  = 10'd100,
    parameter logic [11:0] TIMEOUT = 12'd64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      req,
    input  logic [3:0][9:0] a0,
    input  logic [3:0][9:0] a1,
    input  logic [3:0][9:0] tmpl,
    output logic [1:0]      gnt,
    output logic [2:0]      top_state,
    output logic [3:0][9:0] corr_a,
    output logic [3:0][9:0] corr_b,
    input  logic            corr_finished,
    input  logic [9:0]      corr_max,
    input  logic [11:0]     corr_idx,
    output logic            busy,
    output logic            done,
    output logic            done_id,
    output logic [9:0]      result_max,
    output logic [11:0]     result_idx,
    output logic            match,
    output logic            timeout_err
);

    // Scheduler states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CLEAR   = 2'd1;
    localparam logic [1:0] c_ST_RUN     = 2'd2;
    localparam logic [1:0] c_ST_CAPTURE = 2'd3;

    // Correlator control encodings
    localparam logic [2:0] c_TS_CLEAR = 3'b000;
    localparam logic [2:0] c_TS_RUN   = 3'b010;
    localparam logic [2:0] c_TS_HOLD  = 3'b001;

    logic [1:0]      r_state;
    logic [2:0]      r_top_state;
    logic [11:0]     r_cnt;
    logic            r_id;
    logic            r_done;
    logic            r_done_id;
    logic [3:0][9:0] r_corr_a;
    logic [3:0][9:0] r_corr_b;
    logic [9:0]      r_result_max;
    logic [11:0]     r_result_idx;
    logic            r_match;
    logic            r_timeout_err;

    logic w_grant;
    logic w_win;
    logic w_fin_valid;
    logic w_tmo;

    // A grant is only issued from IDLE, and never while reset is being applied.
    assign w_grant = (r_state == c_ST_IDLE) && reset_n && (req != 2'b00);

`ifdef CORR_SCHED_FIXED_PRIO_EN
    // Requester 1 wins only when requester 0 is not asking.
    assign w_win = req[1] & ~req[0];
`else
    logic r_last;

    // On a tie the requester that was not served last wins.
    assign w_win = (req == 2'b11) ? ~r_last : req[1];

    // Pointer remembers the last served requester; reset value favours requester 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    assign gnt = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;

    // The first RUN cycle (count 0) ignores a finish flag left over from a previous run.
    assign w_fin_valid = corr_finished && (r_cnt != 12'd0);
    assign w_tmo       = (r_cnt == (TIMEOUT - 12'd1));

    // Main sequencer: state, correlator control, operand latch and result capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_top_state   <= c_TS_CLEAR;
            r_cnt         <= 12'd0;
            r_id          <= 1'b0;
            r_done        <= 1'b0;
            r_done_id     <= 1'b0;
            r_corr_a      <= '0;
            r_corr_b      <= '0;
            r_result_max  <= 10'd0;
            r_result_idx  <= 12'd0;
            r_match       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_top_state <= c_TS_HOLD;
                    if (w_grant) begin
                        r_state     <= c_ST_CLEAR;
                        r_top_state <= c_TS_CLEAR;
                        r_cnt       <= 12'd0;
                        r_id        <= w_win;
                        r_corr_a    <= w_win ? a1 : a0;
                        r_corr_b    <= tmpl;
                    end
                end
                c_ST_CLEAR: begin
                    // Counter doubles as the two-cycle CLEAR timer.
                    r_cnt <= r_cnt + 12'd1;
                    if (r_cnt == 12'd1) begin
                        r_state     <= c_ST_RUN;
                        r_top_state <= c_TS_RUN;
                        r_cnt       <= 12'd0;
                    end
                end
                c_ST_RUN: begin
                    r_cnt <= r_cnt + 12'd1;
                    if (w_fin_valid || w_tmo) begin
                        r_state     <= c_ST_CAPTURE;
                        r_top_state <= c_TS_HOLD;
                        r_done      <= 1'b1;
                        r_done_id   <= r_id;
                        // A real finish wins over a simultaneous timeout.
                        if (w_fin_valid) begin
                            r_result_max  <= corr_max;
                            r_result_idx  <= corr_idx;
                            r_match       <= (corr_max >= THRESH);
                            r_timeout_err <= 1'b0;
                        end else begin
                            r_result_max  <= 10'd0;
                            r_result_idx  <= 12'd0;
                            r_match       <= 1'b0;
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_top_state <= c_TS_HOLD;
                end
            endcase
        end
    end

    assign top_state   = r_top_state;
    assign busy        = (r_state != c_ST_IDLE);
    assign done        = r_done;
    assign done_id     = r_done_id;
    assign corr_a      = r_corr_a;
    assign corr_b      = r_corr_b;
    assign result_max  = r_result_max;
    assign result_idx  = r_result_idx;
    assign match       = r_match;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_corr_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_corr_scheduler
//  Description : Self-checking bench for corr_scheduler with a behavioural
//                correlator model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_corr_scheduler;

    typedef logic [3:0][9:0] vec_t;
    typedef struct packed {
        logic        id;
        logic [9:0]  mx;
        logic [11:0] ix;
        logic        m;
        logic        t;
    } res_t;
    typedef struct {
        res_t r;
        int   lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    vec_t        a0, a1, tmpl;
    logic [1:0]  gnt;
    logic [2:0]  top_state;
    vec_t        corr_a, corr_b;
    logic        corr_finished;
    logic [9:0]  corr_max;
    logic [11:0] corr_idx;
    logic        busy, done, done_id;
    logic [9:0]  result_max;
    logic [11:0] result_idx;
    logic        match, timeout_err;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [2:0] ts_log [0:255];

    // correlator model configuration
    int          fin_at = 0;
    bit          stale  = 1'b0;
    logic [9:0]  m_max  = 10'd0;
    logic [11:0] m_idx  = 12'd0;
    int          run_cnt = 0;

    always #5 clk = ~clk;

    corr_scheduler dut (
        .clk(clk), .reset_n(reset_n), .req(req), .a0(a0), .a1(a1), .tmpl(tmpl),
        .gnt(gnt), .top_state(top_state), .corr_a(corr_a), .corr_b(corr_b),
        .corr_finished(corr_finished), .corr_max(corr_max), .corr_idx(corr_idx),
        .busy(busy), .done(done), .done_id(done_id), .result_max(result_max),
        .result_idx(result_idx), .match(match), .timeout_err(timeout_err)
    );

    // Correlator model: raises finish in RUN cycle fin_at (1-based), optional stale flag in RUN cycle 1
    initial begin
        corr_finished = 1'b0;
        corr_max = 10'd0;
        corr_idx = 12'd0;
        forever begin
            @(negedge clk);
            if (top_state === 3'b010) run_cnt++; else run_cnt = 0;
            corr_finished = ((fin_at != 0) && (run_cnt == fin_at)) || (stale && (run_cnt == 1));
            corr_max = m_max;
            corr_idx = m_idx;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(bit id, logic [9:0] mx, logic [11:0] ix, bit tmo, int r);
        exp_t e;
        e.r.id = id;
        e.r.mx = tmo ? 10'd0 : mx;
        e.r.ix = tmo ? 12'd0 : ix;
        e.r.m  = !tmo && (mx >= 10'd100);
        e.r.t  = tmo;
        e.lat  = 1 + 2 + r + 1;
        return e;
    endfunction

    task automatic wait_done(input int budget, input bit drop, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while ((n < budget) && !ok) begin
            @(negedge clk);
            n++;
            if (n < 256) ts_log[n] = top_state;
            if (drop && (n == 1)) begin
                req = 2'b00; a0 = '1; a1 = '1; tmpl = '1;
            end
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if ({top_state, gnt, busy, done, done_id} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %h want 00", {top_state, gnt, busy, done, done_id});
        end
        checks++;
        if ({result_max, result_idx, match, timeout_err} !== 24'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", {result_max, result_idx, match, timeout_err});
        end
        checks++;
        if ({corr_a, corr_b} !== 80'h0) begin
            errors++;
            $display("FAIL reset_operands: got %h want 0", {corr_a, corr_b});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({top_state, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release: top_state/busy got %b want 0010", {top_state, busy});
        end
    endtask

    task automatic test_single();
        int n; bit ok; exp_t e; vec_t va, vt;
        va = {10'd1, 10'd2, 10'd3, 10'd4};
        vt = {10'd1, 10'd1, 10'd1, 10'd1};
        a0 = va; a1 = {10'd5, 10'd6, 10'd7, 10'd8}; tmpl = vt;
        fin_at = 8; stale = 1'b0; m_max = 10'd30; m_idx = 12'd3;
        sb.push_back(mk(1'b0, 10'd30, 12'd3, 1'b0, 8));
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt); end
        wait_done(200, 1'b1, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done: no done after %0d cycles", n); end
        checks++;
        if (n + 1 != e.lat) begin errors++; $display("FAIL single_latency: got %0d want %0d", n + 1, e.lat); end
        checks++;
        if ({ts_log[1], ts_log[2], ts_log[3], top_state} !== 12'b000_000_010_001) begin
            errors++;
            $display("FAIL single_top_state: got %b want 000000010001", {ts_log[1], ts_log[2], ts_log[3], top_state});
        end
        checks++;
        if ({corr_a, corr_b} !== {va, vt}) begin
            errors++;
            $display("FAIL single_operands: got %h want %h", {corr_a, corr_b}, {va, vt});
        end
        checks++;
        if ({done_id, result_max, result_idx, match, timeout_err} !== e.r) begin
            errors++;
            $display("FAIL single_result: got %h want %h", {done_id, result_max, result_idx, match, timeout_err}, e.r);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_capture: got %b want 1", busy); end
        @(negedge clk);
        checks++;
        if ({done, busy, top_state, result_max} !== {2'b00, 3'b001, 10'd30}) begin
            errors++;
            $display("FAIL single_after: got %h want %h", {done, busy, top_state, result_max}, {2'b00, 3'b001, 10'd30});
        end
    endtask

    task automatic test_back_to_back();
        int n; bit ok; exp_t e; logic [1:0] eg; bit ids [3];
`ifdef CORR_SCHED_FIXED_PRIO_EN
        ids = '{1'b0, 1'b0, 1'b0};
`else
        ids = '{1'b0, 1'b1, 1'b0};
`endif
        test_reset();
        a0 = {10'd9, 10'd8, 10'd7, 10'd6}; a1 = {10'd2, 10'd4, 10'd6, 10'd8};
        tmpl = {10'd3, 10'd3, 10'd3, 10'd3};
        fin_at = 3; stale = 1'b0; m_max = 10'd120; m_idx = 12'd7;
        for (int k = 0; k < 3; k++) sb.push_back(mk(ids[k], 10'd120, 12'd7, 1'b0, 3));
        for (int k = 0; k < 3; k++) begin
            if (k == 0) req = 2'b11; else @(negedge clk);
            #1;
            eg = ids[k] ? 2'b10 : 2'b01;
            checks++;
            if ({gnt, top_state} !== {eg, 3'b001}) begin
                errors++;
                $display("FAIL b2b_gnt%0d: got %b want %b", k, {gnt, top_state}, {eg, 3'b001});
            end
            checks++;
            if (corr_a === (ids[k] ? a1 : a0) && k > 0 && ids[k] != ids[k - 1]) begin
                errors++;
                $display("FAIL b2b_early_latch%0d: got %h want previous operand", k, corr_a);
            end
            wait_done(100, 1'b0, n, ok);
            if (k == 2) req = 2'b00;
            e = sb.pop_front();
            checks++;
            if (!ok || (n + 1 != e.lat)) begin
                errors++;
                $display("FAIL b2b_done%0d: seen %b latency got %0d want %0d", k, ok, n + 1, e.lat);
            end
            checks++;
            if ({done_id, result_max, result_idx, match, timeout_err} !== e.r) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h want %h", k, {done_id, result_max, result_idx, match, timeout_err}, e.r);
            end
            checks++;
            if (corr_a !== (ids[k] ? a1 : a0)) begin
                errors++;
                $display("FAIL b2b_operand%0d: got %h want %h", k, corr_a, ids[k] ? a1 : a0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n; bit ok; exp_t e;
        fin_at = 0; stale = 1'b0; m_max = 10'd999; m_idx = 12'd555;
        sb.push_back(mk(1'b1, 10'd999, 12'd555, 1'b1, 64));
        req = 2'b10;
        #1;
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL timeout_gnt: got %b want 10", gnt); end
        wait_done(200, 1'b1, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || (n + 1 != e.lat)) begin
            errors++;
            $display("FAIL timeout_done: seen %b latency got %0d want %0d", ok, n + 1, e.lat);
        end
        checks++;
        if ({done_id, result_max, result_idx, match, timeout_err} !== e.r) begin
            errors++;
            $display("FAIL timeout_result: got %h want %h", {done_id, result_max, result_idx, match, timeout_err}, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_stale_finish();
        int n; bit ok; exp_t e;
        fin_at = 5; stale = 1'b1; m_max = 10'd150; m_idx = 12'd42;
        sb.push_back(mk(1'b0, 10'd150, 12'd42, 1'b0, 5));
        req = 2'b01;
        wait_done(200, 1'b1, n, ok);
        stale = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!ok || (n + 1 != e.lat)) begin
            errors++;
            $display("FAIL stale_done: seen %b latency got %0d want %0d", ok, n + 1, e.lat);
        end
        checks++;
        if ({done_id, result_max, result_idx, match, timeout_err} !== e.r) begin
            errors++;
            $display("FAIL stale_result: got %h want %h", {done_id, result_max, result_idx, match, timeout_err}, e.r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n; bit ok; exp_t e; int k; int cyc;
        fin_at = 4; stale = 1'b0; m_max = 10'd200; m_idx = 12'd11;
        req = 2'b01;
        k = 0; cyc = 0;
        while ((k < 4) && (cyc < 50)) begin
            @(negedge clk);
            cyc++;
            req = 2'b00;
            if (top_state === 3'b010) k++;
        end
        checks++;
        if (k != 4) begin errors++; $display("FAIL midrst_run: RUN cycles got %0d want 4", k); end
        reset_n = 1'b0;
        req = 2'b10;
        @(negedge clk);
        checks++;
        if ({done, busy, gnt, top_state} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_abort: got %b want 0000000", {done, busy, gnt, top_state});
        end
        checks++;
        if ({result_max, match} !== 11'd0) begin
            errors++;
            $display("FAIL midrst_result: got %h want 0", {result_max, match});
        end
        fin_at = 2; m_max = 10'd77; m_idx = 12'd9;
        sb.push_back(mk(1'b1, 10'd77, 12'd9, 1'b0, 2));
        reset_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL midrst_gnt: got %b want 10", gnt); end
        wait_done(100, 1'b1, n, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || (n + 1 != e.lat)) begin
            errors++;
            $display("FAIL midrst_done: seen %b latency got %0d want %0d", ok, n + 1, e.lat);
        end
        checks++;
        if ({done_id, result_max, result_idx, match, timeout_err} !== e.r) begin
            errors++;
            $display("FAIL midrst_result2: got %h want %h", {done_id, result_max, result_idx, match, timeout_err}, e.r);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        req = 2'b00;
        a0 = '0; a1 = '0; tmpl = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_stale_finish();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/corr_scheduler.md
CORR_SCHEDULER -- requirements
Module: corr_scheduler

Interface
REQ-001 Parameter THRESH, default 10'd100, is the match threshold applied to the captured correlation peak.
REQ-002 Parameter TIMEOUT, default 12'd64, is the maximum number of RUN cycles before an abort.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req  in  2  per-requester level request; bit i is requester i.
REQ-006 a0, a1  in  4x10 each  sample windows of requester 0 and requester 1.
REQ-007 tmpl  in  4x10  shared template, applied as correlator b input.
REQ-008 gnt  out  2  one-hot, single-cycle grant/capture acknowledge.
REQ-009 top_state  out  3  correlator control: 3'b000 CLEAR, 3'b010 RUN, 3'b001 HOLD.
REQ-010 corr_a, corr_b  out  4x10 each  latched operands to the correlator.
REQ-011 corr_finished  in  1  correlator completion flag.
REQ-012 corr_max  in  10  correlator peak value.
REQ-013 corr_idx  in  12  correlator peak index.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  single-cycle completion pulse.
REQ-016 done_id  out  1  requester served by the current done pulse.
REQ-017 result_max  out  10  captured peak value.
REQ-018 result_idx  out  12  captured peak index.
REQ-019 match  out  1  high when the captured peak is >= THRESH.
REQ-020 timeout_err  out  1  high when the current result was aborted.

Function
REQ-021 The FSM SHALL use exactly these states:
- IDLE -> CLEAR when any req bit is high.
- CLEAR lasts exactly 2 cycles, then -> RUN.
- RUN -> CAPTURE when corr_finished is sampled high or the timeout fires.
- CAPTURE lasts 1 cycle, then -> IDLE.
REQ-022 In the IDLE cycle that leaves for CLEAR, the block SHALL assert gnt for the winner and, on that edge, latch the winner's a-vector into corr_a and tmpl into corr_b.
REQ-023 corr_a and corr_b SHALL hold constant from CLEAR through CAPTURE.
REQ-024 top_state SHALL be 3'b000 in CLEAR, 3'b010 in RUN, and 3'b001 in IDLE and CAPTURE.
REQ-025 A requester SHALL hold req until it sees gnt; after gnt, req is don't-care for that transaction.
REQ-026 Arbitration SHALL be round-robin: when both bits are high, the requester not served last wins; the pointer updates only on a grant.
REQ-027 corr_finished SHALL be ignored in the first RUN cycle, to reject a stale flag.
REQ-028 A 12-bit run counter SHALL clear on RUN entry, increment each RUN cycle, and fire the timeout when count == TIMEOUT-1 without a finish.
REQ-029 On finish, the CAPTURE-entry edge SHALL register corr_max -> result_max, corr_idx -> result_idx, (corr_max >= THRESH) -> match, and 0 -> timeout_err.
REQ-030 On timeout, the CAPTURE-entry edge SHALL register result_max=0, result_idx=0, match=0, timeout_err=1.
REQ-031 If finish and timeout occur in the same cycle, finish SHALL take priority.
REQ-032 done SHALL pulse in the CAPTURE cycle, with done_id equal to the granted requester.
REQ-033 result_* and match SHALL hold until the next capture.
REQ-034 A request arriving while busy SHALL wait; it is granted in the first IDLE cycle.
REQ-035 With req held continuously, transactions SHALL be back-to-back.
REQ-036 Latency from req high in IDLE to done SHALL be 1 + 2 + R + 1 cycles, where R is the number of RUN cycles.

Reset
REQ-037 While reset_n is low at a clock edge, the next state SHALL be IDLE, with:
- top_state=3'b000, gnt=0, busy=0, done=0, done_id=0;
- result_max=0, result_idx=0, match=0, timeout_err=0;
- corr_a=0, corr_b=0, RR pointer favouring requester 0, run counter=0.
REQ-038 Reset asserted mid-transaction SHALL abort it without a done pulse.
REQ-039 The first post-reset IDLE cycle SHALL drive top_state 3'b001.

Configuration
REQ-040 With macro CORR_SCHED_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the RR pointer SHALL be omitted.
REQ-041 Without CORR_SCHED_FIXED_PRIO_EN, round-robin arbitration per REQ-026 SHALL apply.

Verification
REQ-042 Reset sequence: reset_n=0 for 2 cycles, then 1 -> all outputs at reset values, top_state=3'b001 on the first cycle after release.
REQ-043 Single request with a0={1,2,3,4}, tmpl={1,1,1,1}; model finishes after 8 RUN cycles with corr_max=30, corr_idx=3 -> gnt=2'b01, done at cycle 12 after req, result_max=30, result_idx=3, match=0.
REQ-044 Simultaneous req=2'b11 held high -> grants in order 01, 10, 01 (or 01, 01, 01 with the macro), done_id 0, 1, 0.
REQ-045 Model never finishes, TIMEOUT=64 -> done after 64 RUN cycles, timeout_err=1, result_max=0, match=0.
REQ-046 Stale corr_finished high at RUN entry, then a true finish at the 5th RUN cycle with corr_max=150 -> capture occurs at the true finish, match=1.
REQ-047 reset_n pulsed low during RUN -> no done pulse, IDLE next cycle, a pending req is granted afterwards.
